// File: rtl/hsv_core_alu_commit_if.sv
// Shared types and the commit/writeback/retire bus for hsv_core_alu_commit.
// hsv_core_pkg fixes all widths (word = 32 bits).

package hsv_core_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Retiring ALU result as presented by the execute stage
  typedef struct packed {
    word_t    pc;
    reg_idx_t rd;
    word_t    result;
    logic     writeback;
  } commit_data_t;

endpackage

// Producer (master) drives commit beats and flush requests; the commit stage (slave)
// answers with ready/ack and drives the register-file write and retire status.
interface hsv_core_alu_commit_if;
  import hsv_core_pkg::*;

  logic         flush_req;
  logic         flush_ack;
  commit_data_t commit_data;
  logic         in_valid;
  logic         in_ready;
  logic         rf_wr_en;
  reg_idx_t     rf_wr_addr;
  word_t        rf_wr_data;
  logic         retire_valid;
  word_t        retire_pc;
  word_t        retire_count;

  modport master (
    output flush_req, commit_data, in_valid,
    input  flush_ack, in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
           retire_valid, retire_pc, retire_count
  );

  modport slave (
    input  flush_req, commit_data, in_valid,
    output flush_ack, in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
           retire_valid, retire_pc, retire_count
  );

endinterface

// File: rtl/hsv_core_alu_commit.sv
// ALU commit stage: registers retiring results into a register-file write and
// retire status one cycle after acceptance, and handshakes pipeline flushes
// through RUN -> DRAIN -> ACK.
// Optional feature: define HSV_CORE_RETIRE_COUNTER_EN to build the retire counter;
// otherwise retire_count is tied to 0 and no counter flops exist.

module hsv_core_alu_commit
  import hsv_core_pkg::*;
(
  input logic                  clk_core,
  input logic                  rst_core,
  hsv_core_alu_commit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e   state_q, state_d;
  logic     in_ready_c;
  logic     accept_c;

  logic     rf_wr_en_q,     rf_wr_en_d;
  reg_idx_t rf_wr_addr_q,   rf_wr_addr_d;
  word_t    rf_wr_data_q,   rf_wr_data_d;
  logic     retire_valid_q, retire_valid_d;
  word_t    retire_pc_q,    retire_pc_d;

  // State register
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake; ready never looks at in_valid
  always_comb begin
    state_d    = state_q;
    in_ready_c = (state_q == RUN) & ~bus.flush_req;
    accept_c   = in_ready_c & bus.in_valid;
    case (state_q)
      RUN:     if (bus.flush_req) state_d = DRAIN;
      DRAIN:   if (!bus.in_valid) state_d = ACK;
      ACK:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Writeback/retire next values; x0 writes are dropped but still retire
  always_comb begin
    rf_wr_en_d     = accept_c & bus.commit_data.writeback & (bus.commit_data.rd != '0);
    rf_wr_addr_d   = rf_wr_addr_q;
    rf_wr_data_d   = rf_wr_data_q;
    retire_valid_d = accept_c;
    retire_pc_d    = retire_pc_q;
    if (accept_c) begin
      rf_wr_addr_d = bus.commit_data.rd;
      rf_wr_data_d = bus.commit_data.result;
      retire_pc_d  = bus.commit_data.pc;
    end
  end

  // Writeback/retire registers; reset also cancels a pending write
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      rf_wr_en_q     <= 1'b0;
      rf_wr_addr_q   <= '0;
      rf_wr_data_q   <= '0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
    end else begin
      rf_wr_en_q     <= rf_wr_en_d;
      rf_wr_addr_q   <= rf_wr_addr_d;
      rf_wr_data_q   <= rf_wr_data_d;
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
    end
  end

`ifdef HSV_CORE_RETIRE_COUNTER_EN
  word_t retire_count_q, retire_count_d;

  // Counts every accepted beat, wrapping naturally at 2^32
  always_comb begin
    retire_count_d = retire_count_q;
    if (accept_c) retire_count_d = retire_count_q + WORD_W'(1);
  end

  // Retire counter register
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      retire_count_q <= '0;
    end else begin
      retire_count_q <= retire_count_d;
    end
  end

  assign bus.retire_count = retire_count_q;
`else
  assign bus.retire_count = '0;
`endif

  assign bus.in_ready     = in_ready_c;
  assign bus.flush_ack    = (state_q == ACK);
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_wr_addr   = rf_wr_addr_q;
  assign bus.rf_wr_data   = rf_wr_data_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_pc    = retire_pc_q;

endmodule
